// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity constants and divider helper
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversample tick generator, restartable to align with a start edge
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = !restart && (cnt == CW'(DIV - 1));

    // free-running divider, zeroed on restart so the first tick lands DIV clocks later
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cnt <= '0;
        else if (restart || cnt == CW'(DIV - 1)) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with majority-vote sampling and valid/ready output
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int SYS_CLK_HZ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] para_out,
    output logic                 valid_flag,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int   DIV     = calc_div(SYS_CLK_HZ, BAUD_RATE);
    localparam logic PAR_INV = (PARITY == PARITY_ODD);

    rx_state_t state, next_state;
    logic rx_meta, rx_s, rx_prev;
    logic tick, restart, decide, vote, done, fall;
    logic [3:0] sub;
    logic s7, s8;
    logic [2:0] bit_cnt;
    logic stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic ferr_acc, perr_acc;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .restart  (restart),
        .tick     (tick)
    );

    assign fall   = rx_prev & ~rx_s;
    assign decide = tick && sub == 4'd9;
    assign vote   = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

    // two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) {rx_meta, rx_s, rx_prev} <= 3'b111;
        else {rx_meta, rx_s, rx_prev} <= {rx, rx_meta, rx_s};
    end

    // state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else state <= next_state;
    end

    // next-state logic; a frame completes at the final stop-bit decision
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                restart    = fall;
                next_state = fall ? S_START : S_IDLE;
            end
            S_START:
                if (decide) next_state = vote ? S_IDLE : S_DATA;
            S_DATA:
                if (decide && bit_cnt == 3'(DATA_BITS - 1))
                    next_state = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY:
                if (decide) next_state = S_STOP;
            S_STOP:
                if (decide && stop_cnt == 1'(STOP_BITS - 1)) begin
                    done       = 1'b1;
                    next_state = vote ? S_IDLE : S_BREAK_WAIT;
                end
            S_BREAK_WAIT:
                if (rx_s) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // sub-bit counter, vote samples, shift register and per-frame error accumulation
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sub      <= '0;
            s7       <= 1'b1;
            s8       <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
        end else begin
            if (restart) sub <= '0;
            else if (tick) sub <= sub + 4'd1;
            if (tick && sub == 4'd7) s7 <= rx_s;
            if (tick && sub == 4'd8) s8 <= rx_s;
            if (decide) begin
                case (state)
                    S_START: begin
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        ferr_acc <= 1'b0;
                        perr_acc <= 1'b0;
                    end
                    S_DATA: begin
                        shift   <= {vote, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: perr_acc <= vote ^ (^shift) ^ PAR_INV;
                    S_STOP: begin
                        ferr_acc <= ferr_acc | ~vote;
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // output holding register with valid/ready handshake and overrun detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            para_out    <= '0;
            valid_flag  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= done && valid_flag && !ready;
            if (done && (!valid_flag || ready)) begin
                para_out   <= shift;
                frame_err  <= ferr_acc | ~vote;
                parity_err <= perr_acc;
                valid_flag <= 1'b1;
            end else if (valid_flag && ready) begin
                valid_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized and directed checks of uart_rx_cfg against a frame-level model
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 10000;
    localparam int BITCLK = 160;

    // dut0 = 8N1, dut1 = 7E1, dut2 = 7O2
    int nb [3] = '{8, 7, 7};
    int pm [3] = '{0, 1, 2};
    int ns [3] = '{1, 1, 2};

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [2:0] ready = 3'b111;
    logic [7:0] p0;
    logic [6:0] p1, p2;
    logic [2:0] vf, fe, pe, oe;
    int errors = 0;
    int checks = 0;
    int vcyc [3] = '{0, 0, 0};
    int ovr  [3] = '{0, 0, 0};
    logic [9:0] got0[$], got1[$], got2[$];

    always #5 sys_clk = ~sys_clk;

    uart_rx_cfg #(.SYS_CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx[0]), .ready(ready[0]), .para_out(p0),
        .valid_flag(vf[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun_err(oe[0]));
    uart_rx_cfg #(.SYS_CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx[1]), .ready(ready[1]), .para_out(p1),
        .valid_flag(vf[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun_err(oe[1]));
    uart_rx_cfg #(.SYS_CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx[2]), .ready(ready[2]), .para_out(p2),
        .valid_flag(vf[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun_err(oe[2]));

    // capture every accepted word and count valid cycles / overrun pulses
    always @(negedge sys_clk) begin
        if (vf[0] && ready[0]) got0.push_back({p0, fe[0], pe[0]});
        if (vf[1] && ready[1]) got1.push_back({1'b0, p1, fe[1], pe[1]});
        if (vf[2] && ready[2]) got2.push_back({1'b0, p2, fe[2], pe[2]});
        for (int i = 0; i < 3; i++) begin
            if (vf[i]) vcyc[i]++;
            if (oe[i]) ovr[i]++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? got0.size() : (w == 1) ? got1.size() : got2.size();
    endfunction

    function automatic logic [9:0] qpop(input int w);
        return (w == 0) ? got0.pop_front() : (w == 1) ? got1.pop_front() : got2.pop_front();
    endfunction

    task automatic send_bits(input int w, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx[w] = bits[i];
            clk(BITCLK);
        end
        rx[w] = 1'b1;
    endtask

    task automatic expect_frame(input int w, input logic [7:0] ed, input logic ef, input logic ep);
        logic [9:0] v;
        int t;
        t = 0;
        while (qsize(w) == 0 && t < 300) begin
            clk(1);
            t++;
        end
        if (qsize(w) == 0) begin
            check_val($sformatf("dut%0d frame_timeout", w), 0, 1);
            return;
        end
        v = qpop(w);
        check_val($sformatf("dut%0d para_out", w), 32'(v[9:2]), 32'(ed));
        check_val($sformatf("dut%0d frame_err", w), 32'(v[1]), 32'(ef));
        check_val($sformatf("dut%0d parity_err", w), 32'(v[0]), 32'(ep));
    endtask

    // frame-level model: build the line waveform and the word the receiver must report
    function automatic logic [11:0] build(input int w, input logic [7:0] d, input bit badp,
                                          input bit bads, output int n);
        logic [11:0] bits;
        logic [7:0] m;
        m = 8'((1 << nb[w]) - 1);
        bits = '1;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nb[w]; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pm[w] != 0) begin
            bits[n] = (^(d & m)) ^ (pm[w] == 2) ^ badp;
            n++;
        end
        bits[n] = ~bads;
        n += ns[w];
        return bits;
    endfunction

    task automatic frame(input int w, input logic [7:0] d, input bit badp, input bit bads);
        logic [11:0] bits;
        int n;
        bits = build(w, d, badp, bads, n);
        send_bits(w, bits, n);
        clk(20);
        expect_frame(w, d & 8'((1 << nb[w]) - 1), bads, (pm[w] != 0) && badp);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " para_out"}, {p0, 1'b0, p1, 1'b0, p2}, 0);
        check_val({tag, " valid"}, 32'(vf), 0);
        check_val({tag, " errs"}, {fe, pe, oe}, 0);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, o0, n;
        logic [11:0] bits;
        clk(3);
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        clk(20);

        // 8N1 0xA5, valid high exactly one clock
        v0 = vcyc[0];
        frame(0, 8'hA5, 1'b0, 1'b0);
        check_val("A5 valid_cycles", vcyc[0] - v0, 1);

        // 7E1 0x35 with wrong parity, then 7O2 with correct odd parity
        frame(1, 8'h35, 1'b1, 1'b0);
        frame(2, 8'h35, 1'b0, 1'b0);

        // 60-clock glitch is a false start
        v0 = vcyc[0];
        rx[0] = 1'b0;
        clk(60);
        rx[0] = 1'b1;
        clk(300);
        check_val("glitch no_valid", vcyc[0] - v0, 0);
        check_val("glitch idle", 32'(dut0.state), 32'(S_IDLE));
        frame(0, 8'h3C, 1'b0, 1'b0);

        // line break: one 0x00 frame with frame_err, then nothing until rx high
        rx[0] = 1'b0;
        clk(2000);
        check_val("break frames", qsize(0), 1);
        check_val("break wait", 32'(dut0.state), 32'(S_BREAK_WAIT));
        expect_frame(0, 8'h00, 1'b1, 1'b0);
        rx[0] = 1'b1;
        clk(400);
        check_val("break no_more", qsize(0), 0);
        check_val("break idle", 32'(dut0.state), 32'(S_IDLE));

        // back-to-back with ready low: 0x11 held, 0x22 dropped
        ready[0] = 1'b0;
        o0 = ovr[0];
        bits = build(0, 8'h11, 1'b0, 1'b0, n);
        send_bits(0, bits, n);
        bits = build(0, 8'h22, 1'b0, 1'b0, n);
        send_bits(0, bits, n);
        clk(50);
        check_val("ovr valid", 32'(vf[0]), 1);
        check_val("ovr held", 32'(p0), 32'h11);
        check_val("ovr pulses", ovr[0] - o0, 1);
        ready[0] = 1'b1;
        clk(1);
        check_val("ovr dropped", 32'(vf[0]), 0);
        expect_frame(0, 8'h11, 1'b0, 1'b0);

        // reset mid-DATA of 0x5A aborts the frame
        bits = build(0, 8'h5A, 1'b0, 1'b0, n);
        send_bits(0, bits, 4);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        clk(3);
        sys_rst_n = 1'b1;
        clk(20);
        frame(0, 8'h5A, 1'b0, 1'b0);

        // randomized frames on all three configurations
        for (int r = 0; r < 4; r++)
            for (int w = 0; w < 3; w++)
                frame(w, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        clk(200);
        check_val("stray0", qsize(0), 0);
        check_val("stray1", qsize(1), 0);
        check_val("stray2", qsize(2), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
